uart_reg_bank_fifo: RTL and testbench

Parametrised successor to the UART register block. It adds a bus-side read/write port, TX and RX data FIFOs, sticky write-1-to-clear status, FIFO level reporting and a maskable interrupt. It sits between the APB slave controller and the UART TX/RX engines. The UART engines pull TX bytes through a valid/pop handshake and push RX bytes into the block.

---
 rtl/uart_reg_bank_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_reg_bank_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_bank_fifo.sv
// rtl/uart_reg_bank_fifo.sv - UART register bank with TX/RX FIFOs, W1C status and maskable irq
module uart_reg_bank_fifo #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int LVL_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [4:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_pop,
  input  logic              tx_done,
  input  logic              rx_push,
  input  logic [DATA_W-1:0] rx_data_in,
  input  logic              rx_parity_err,
  output logic [4:0]        cfg_out,
  output logic              irq
);
  localparam int TPW = $clog2(TX_DEPTH);
  localparam int RPW = $clog2(RX_DEPTH);
  localparam logic [4:0] A_TX = 5'h00, A_RX = 5'h04, A_CFG = 5'h08, A_CTRL = 5'h0C,
                         A_STAT = 5'h10, A_IEN = 5'h14, A_LVL = 5'h18;

  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TPW-1:0]    tx_wr_ptr, tx_rd_ptr;
  logic [RPW-1:0]    rx_wr_ptr, rx_rd_ptr;
  logic [LVL_W-1:0]  tx_count, rx_count;
  logic [4:0]        cfg, irq_en, status, status_set, status_clr;
  logic              tx_en;
  logic [31:0]       rd_next;
  logic              unused_wr;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_flush, rx_flush, tx_push_req, tx_push_ok, tx_pop_ok, rx_push_ok, rx_pop_ok;

  assign unused_wr = ^wr_data[31:DATA_W];

  assign tx_full  = (tx_count == LVL_W'(TX_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == LVL_W'(RX_DEPTH));
  assign rx_empty = (rx_count == '0);

  assign tx_valid = tx_en && !tx_empty;
  assign tx_data  = tx_mem[tx_rd_ptr];
  assign cfg_out  = cfg;

  assign tx_flush    = wr_en && (addr == A_CTRL) && wr_data[1];
  assign rx_flush    = wr_en && (addr == A_CTRL) && wr_data[2];
  assign tx_pop_ok   = tx_pop && tx_valid;
  assign tx_push_req = wr_en && (addr == A_TX);
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign tx_push_ok  = tx_push_req && (!tx_full || tx_pop_ok);
  assign rx_pop_ok   = rd_en && (addr == A_RX) && !rx_empty;
  assign rx_push_ok  = rx_push && (!rx_full || rx_pop_ok);

  assign status_set = {tx_push_req && !tx_push_ok, rx_push && !rx_push_ok,
                       rx_push_ok && rx_parity_err, rx_push_ok, tx_done};
  assign status_clr = (wr_en && (addr == A_STAT)) ? wr_data[4:0] : 5'b0;

  always_ff @(posedge clk) begin
    if (tx_push_ok && !tx_flush) tx_mem[tx_wr_ptr] <= wr_data[DATA_W-1:0];
    if (rx_push_ok && !rx_flush) rx_mem[rx_wr_ptr] <= rx_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else if (tx_flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + TPW'(1);
      if (tx_pop_ok)  tx_rd_ptr <= tx_rd_ptr + TPW'(1);
      case ({tx_push_ok, tx_pop_ok})
        2'b10:   tx_count <= tx_count + LVL_W'(1);
        2'b01:   tx_count <= tx_count - LVL_W'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else if (rx_flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + RPW'(1);
      if (rx_pop_ok)  rx_rd_ptr <= rx_rd_ptr + RPW'(1);
      case ({rx_push_ok, rx_pop_ok})
        2'b10:   rx_count <= rx_count + LVL_W'(1);
        2'b01:   rx_count <= rx_count - LVL_W'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_comb begin
    rd_next = 32'b0;
    case (addr)
      A_RX:    rd_next = rx_empty ? 32'b0 : 32'(rx_mem[rx_rd_ptr]);
      A_CFG:   rd_next = {27'b0, cfg};
      A_CTRL:  rd_next = {31'b0, tx_en};
      A_STAT:  rd_next = {20'b0, rx_empty, rx_full, tx_empty, tx_full, 3'b0, status};
      A_IEN:   rd_next = {27'b0, irq_en};
      A_LVL:   rd_next = {{(16-LVL_W){1'b0}}, rx_count, {(16-LVL_W){1'b0}}, tx_count};
      default: rd_next = 32'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg     <= '0;
      tx_en   <= 1'b0;
      irq_en  <= '0;
      status  <= '0;
      irq     <= 1'b0;
      rd_data <= '0;
    end else begin
      if (wr_en && (addr == A_CFG))  cfg    <= wr_data[4:0];
      if (wr_en && (addr == A_CTRL)) tx_en  <= wr_data[0];
      if (wr_en && (addr == A_IEN))  irq_en <= wr_data[4:0];
      // Set events override a same-cycle write-1-to-clear
      status  <= (status & ~status_clr) | status_set;
      irq     <= |(status & irq_en);
      rd_data <= rd_en ? rd_next : 32'b0;
    end
  end
endmodule

// File: tb/tb_uart_reg_bank_fifo.sv
// tb/tb_uart_reg_bank_fifo.sv - directed scoreboard bench for uart_reg_bank_fifo
module tb_uart_reg_bank_fifo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_pop, tx_done, rx_push, rx_parity_err;
  logic [7:0]  rx_data_in;
  logic [4:0]  cfg_out;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_q [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  rx_q [$];

  uart_reg_bank_fifo #(.DATA_W(8), .TX_DEPTH(8), .RX_DEPTH(8), .LVL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_pop(tx_pop), .tx_done(tx_done), .rx_push(rx_push), .rx_data_in(rx_data_in),
    .rx_parity_err(rx_parity_err), .cfg_out(cfg_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bw(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic br(input logic [4:0] a, input logic [31:0] exp, input string tag);
    rd_q.push_back(exp);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
    chk(tag, rd_data, rd_q.pop_front());
  endtask

  task automatic tx_push(input logic [7:0] d, input bit expect_accept);
    if (expect_accept) tx_q.push_back(d);
    bw(5'h00, {24'b0, d});
  endtask

  task automatic pop_tx(input string tag);
    chk({tag, "_valid"}, {31'b0, tx_valid}, 32'd1);
    chk({tag, "_data"}, {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
    tx_pop = 1'b1;
    tick();
    tx_pop = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] d, input logic perr, input bit expect_accept);
    if (expect_accept) rx_q.push_back(d);
    rx_push = 1'b1; rx_data_in = d; rx_parity_err = perr;
    tick();
    rx_push = 1'b0; rx_parity_err = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
    tx_pop = 1'b0; tx_done = 1'b0; rx_push = 1'b0; rx_data_in = '0; rx_parity_err = 1'b0;
    tick(); tick();
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_cfg_out", {27'b0, cfg_out}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int a = 0; a <= 'h1C; a += 4)
      br(a[4:0], (a == 'h10) ? 32'h0A00 : 32'd0, $sformatf("rst_read_%0h", a));
    chk("rd_idle_zero", rd_data, 32'd0);

    bw(5'h0C, 32'h1);
    tx_push(8'h41, 1); tx_push(8'h42, 1); tx_push(8'h43, 1);
    chk("tx_head", {24'b0, tx_data}, 32'h41);
    br(5'h18, 32'h3, "level_tx3");
    pop_tx("pop0"); pop_tx("pop1"); pop_tx("pop2");
    chk("tx_valid_drained", {31'b0, tx_valid}, 32'd0);
    br(5'h10, 32'h0A00, "status_tx_empty");
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    br(5'h10, 32'h0A01, "status_tx_done");
    bw(5'h10, 32'h1);
    br(5'h10, 32'h0A00, "status_tx_done_clr");

    bw(5'h0C, 32'h0);
    for (int i = 0; i < 8; i++) tx_push(8'h10 + 8'(i), 1);
    br(5'h18, 32'h8, "level_tx8");
    br(5'h10, 32'h0900, "status_tx_full");
    tx_push(8'h99, 0);
    br(5'h10, 32'h0910, "status_tx_ovf");
    bw(5'h10, 32'h10);
    br(5'h10, 32'h0900, "status_ovf_clr");
    bw(5'h0C, 32'h1);
    chk("tx_head_full", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
    tx_q.push_back(8'h99);
    wr_en = 1'b1; addr = 5'h00; wr_data = 32'h99; tx_pop = 1'b1;
    tick();
    wr_en = 1'b0; tx_pop = 1'b0;
    br(5'h18, 32'h8, "level_push_pop");
    br(5'h10, 32'h0900, "status_no_ovf");
    pop_tx("pop_after_full");
    bw(5'h0C, 32'h3);
    tx_q.delete();
    chk("flush_tx_valid", {31'b0, tx_valid}, 32'd0);
    br(5'h18, 32'h0, "level_flush");
    br(5'h0C, 32'h1, "ctrl_selfclear");
    tx_pop = 1'b1; tick(); tx_pop = 1'b0;
    br(5'h18, 32'h0, "level_pop_empty");
    for (int i = 0; i < 4; i++) tx_push(8'hA0 + 8'(i), 1);
    chk("tx_valid_4", {31'b0, tx_valid}, 32'd1);
    br(5'h18, 32'h4, "level_tx4");
    bw(5'h0C, 32'h3);
    tx_q.delete();
    chk("flush4_tx_valid", {31'b0, tx_valid}, 32'd0);
    br(5'h18, 32'h0, "level_flush4");

    for (int i = 0; i < 9; i++) push_rx(8'h55, (i == 1), (i < 8));
    br(5'h10, 32'h060E, "status_rx_full");
    br(5'h18, 32'h0008_0000, "level_rx8");
    while (rx_q.size() > 0) br(5'h04, {24'b0, rx_q.pop_front()}, "rx_read");
    br(5'h04, 32'h0, "rx_read_empty");
    br(5'h10, 32'h0A0E, "status_rx_drained");
    bw(5'h10, 32'h1F);
    br(5'h10, 32'h0A00, "status_all_clr");

    bw(5'h14, 32'h2);
    br(5'h14, 32'h2, "irq_en_rb");
    push_rx(8'h33, 0, 1);
    chk("irq_one_cycle", {31'b0, irq}, 32'd0);
    tick();
    chk("irq_two_cycles", {31'b0, irq}, 32'd1);
    rx_q.push_back(8'h44);
    wr_en = 1'b1; addr = 5'h10; wr_data = 32'h2; rx_push = 1'b1; rx_data_in = 8'h44;
    tick();
    wr_en = 1'b0; rx_push = 1'b0;
    tick();
    chk("irq_set_wins", {31'b0, irq}, 32'd1);
    br(5'h10, 32'h0202, "status_set_wins");
    while (rx_q.size() > 0) br(5'h04, {24'b0, rx_q.pop_front()}, "rx_read_irq");
    bw(5'h10, 32'h2);
    tick();
    chk("irq_cleared", {31'b0, irq}, 32'd0);

    bw(5'h08, 32'hFFFF_FFFF);
    chk("cfg_out", {27'b0, cfg_out}, 32'h1F);
    br(5'h08, 32'h1F, "cfg_rb");
    bw(5'h1C, 32'hFFFF_FFFF);
    br(5'h1C, 32'h0, "unmapped");
    push_rx(8'h77, 0, 1);
    tick();
    chk("irq_pre_reset", {31'b0, irq}, 32'd1);
    tx_push(8'h01, 1); tx_push(8'h02, 1);
    rd_en = 1'b1; addr = 5'h18;
    @(posedge clk); #2;
    chk("rd_pre_reset", rd_data, 32'h0001_0002);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_data", rd_data, 32'd0);
    chk("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("mid_rst_cfg_out", {27'b0, cfg_out}, 32'd0);
    chk("mid_rst_irq", {31'b0, irq}, 32'd0);
    rd_en = 1'b0;
    tx_q.delete(); rx_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    br(5'h18, 32'h0, "level_after_rst");
    br(5'h10, 32'h0A00, "status_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
